frame_receiver: RTL and testbench

Receive-side counterpart of the frame sender in the delay tester. It terminates the MAC receive byte interface and checks each incoming frame byte-for-byte against the expected sample frame. On a matching, MAC-validated frame it pulses `frame_received` to the timer module, which closes the round-trip delay measurement. It also drives the MAC receive configuration pins.

---
 rtl/frame_pkg.sv | 37 +++
 rtl/frame_rx_stats.sv | 41 ++++
 rtl/frame_receiver.sv | 174 +++++++++++++++++
 tb/tb_frame_receiver.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// rtl/frame_pkg.sv - sample frame, Ethernet/MAC constants and receiver states shared with the sender
package frame_pkg;

  localparam int SAMPLE_FRAME_SIZE = 60;

  localparam logic [47:0] MAC_BROADCAST = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] MAC_LOCAL     = 48'h02_00_00_00_00_01;
  localparam logic [47:0] MAC_UNKNOWN   = 48'h00_00_00_00_00_00;

  localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;

  localparam logic [15:0] ARP_HTYPE_ETH    = 16'h0001;
  localparam logic [15:0] ARP_OPER_REQUEST = 16'h0001;
  localparam logic [31:0] IP_LOCAL         = 32'hC0_A8_01_01;
  localparam logic [31:0] IP_PEER          = 32'hC0_A8_01_02;

  // ARP request padded to the 60-byte Ethernet minimum; byte 0 in the MSBs.
  localparam logic [8*SAMPLE_FRAME_SIZE-1:0] SAMPLE_FRAME = {
    MAC_BROADCAST, MAC_LOCAL, ETH_TYPE_ARP,
    ARP_HTYPE_ETH, ETH_TYPE_IPV4, 8'h06, 8'h04, ARP_OPER_REQUEST,
    MAC_LOCAL, IP_LOCAL, MAC_UNKNOWN, IP_PEER,
    144'h0
  };

  typedef enum logic [1:0] {
    RX_SYNC,
    RX_IDLE,
    RX_RECV,
    RX_STATUS
  } rx_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/frame_rx_stats.sv
// rtl/frame_rx_stats.sv - saturating good/error/timeout frame counters
module frame_rx_stats
  import frame_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        good_pulse,
  input  logic        err_pulse,
  input  logic        timeout_pulse,
  output logic [15:0] good_cnt,
  output logic [15:0] err_cnt,
  output logic [15:0] timeout_cnt
);

  logic [15:0] good_cnt_q, good_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [15:0] timeout_cnt_q, timeout_cnt_d;

  always_comb begin
    good_cnt_d    = good_pulse    ? sat_inc16(good_cnt_q)    : good_cnt_q;
    err_cnt_d     = err_pulse     ? sat_inc16(err_cnt_q)     : err_cnt_q;
    timeout_cnt_d = timeout_pulse ? sat_inc16(timeout_cnt_q) : timeout_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      good_cnt_q    <= '0;
      err_cnt_q     <= '0;
      timeout_cnt_q <= '0;
    end else begin
      good_cnt_q    <= good_cnt_d;
      err_cnt_q     <= err_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
    end
  end

  assign good_cnt    = good_cnt_q;
  assign err_cnt     = err_cnt_q;
  assign timeout_cnt = timeout_cnt_q;

endmodule

// File: rtl/frame_receiver.sv
// rtl/frame_receiver.sv - checks received frames against the sample frame; FRAME_RECEIVER_STATS_EN adds counters
module frame_receiver
  import frame_pkg::*;
#(
  parameter int                          EXP_FRAME_SIZE = SAMPLE_FRAME_SIZE,
  parameter logic [8*EXP_FRAME_SIZE-1:0] EXP_FRAME      = SAMPLE_FRAME,
  parameter int                          STATUS_TIMEOUT = 16
) (
  input  logic        rx_clk,
  input  logic        reset,
  output logic        conf_rx_en,
  output logic        conf_rx_jumbo_en,
  output logic        conf_rx_no_chk_crc,
  input  logic [7:0]  mac_rx_data,
  input  logic        mac_rx_dvld,
  input  logic        mac_rx_goodframe,
  input  logic        mac_rx_badframe,
  output logic        frame_received,
  output logic        frame_error,
  output logic [15:0] rx_len
`ifdef FRAME_RECEIVER_STATS_EN
  ,
  output logic [15:0] good_cnt,
  output logic [15:0] err_cnt,
  output logic [15:0] timeout_cnt
`endif
);

  localparam logic [15:0] FRAME_LEN = 16'(EXP_FRAME_SIZE);
  localparam logic [15:0] TMO_LAST  = 16'(STATUS_TIMEOUT - 1);

  rx_state_e   state_q, state_d;
  logic [15:0] idx_q, idx_d;
  logic [15:0] tmo_q, tmo_d;
  logic [15:0] rx_len_q, rx_len_d;
  logic        mism_q, mism_d;
  logic        stat_good_q, stat_good_d;
  logic        stat_bad_q, stat_bad_d;
  logic        conf_rx_en_q;
  logic        frame_received_q, frame_received_d;
  logic        frame_error_q, frame_error_d;
  logic        timeout_d;

  logic [15:0] cur_idx, byte_off;
  logic [7:0]  exp_byte;
  logic        byte_diff, st_good, st_bad, st_any, pass;

  // Outside RECV a valid byte always opens a new frame at index 0.
  always_comb begin
    cur_idx   = (state_q == RX_RECV) ? idx_q : 16'd0;
    byte_off  = FRAME_LEN - 16'd1 - cur_idx;
    exp_byte  = 8'(EXP_FRAME >> {byte_off, 3'b000});
    byte_diff = (cur_idx < FRAME_LEN) && (mac_rx_data != exp_byte);
    st_good   = stat_good_q | mac_rx_goodframe;
    st_bad    = stat_bad_q | mac_rx_badframe;
    st_any    = st_good | st_bad;
    pass      = st_good && !st_bad && !mism_q && (idx_q >= FRAME_LEN);
  end

  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    tmo_d            = tmo_q;
    rx_len_d         = rx_len_q;
    mism_d           = mism_q;
    stat_good_d      = stat_good_q;
    stat_bad_d       = stat_bad_q;
    frame_received_d = 1'b0;
    frame_error_d    = 1'b0;
    timeout_d        = 1'b0;
    case (state_q)
      RX_SYNC: begin
        if (!mac_rx_dvld) state_d = RX_IDLE;
      end
      RX_IDLE: begin
        if (mac_rx_dvld) begin
          state_d     = RX_RECV;
          idx_d       = sat_inc16(cur_idx);
          mism_d      = byte_diff;
          stat_good_d = 1'b0;
          stat_bad_d  = 1'b0;
        end
      end
      RX_RECV: begin
        // Keep a status pulse that lands before STATUS is reached.
        stat_good_d = stat_good_q | mac_rx_goodframe;
        stat_bad_d  = stat_bad_q | mac_rx_badframe;
        if (mac_rx_dvld) begin
          idx_d  = sat_inc16(idx_q);
          mism_d = mism_q | byte_diff;
        end else begin
          state_d = RX_STATUS;
          tmo_d   = 16'd0;
        end
      end
      RX_STATUS: begin
        if (st_any || mac_rx_dvld || (tmo_q == TMO_LAST)) begin
          frame_received_d = st_any && pass;
          frame_error_d    = !(st_any && pass);
          timeout_d        = !st_any && !mac_rx_dvld;
          rx_len_d         = idx_q;
          state_d          = RX_IDLE;
          stat_good_d      = 1'b0;
          stat_bad_d       = 1'b0;
        end else begin
          tmo_d = sat_inc16(tmo_q);
        end
        if (mac_rx_dvld) begin
          state_d = RX_RECV;
          idx_d   = sat_inc16(cur_idx);
          mism_d  = byte_diff;
        end
      end
      default: state_d = RX_SYNC;
    endcase
  end

  always_ff @(posedge rx_clk or posedge reset) begin
    if (reset) begin
      state_q          <= RX_SYNC;
      idx_q            <= '0;
      tmo_q            <= '0;
      rx_len_q         <= '0;
      mism_q           <= 1'b0;
      stat_good_q      <= 1'b0;
      stat_bad_q       <= 1'b0;
      conf_rx_en_q     <= 1'b0;
      frame_received_q <= 1'b0;
      frame_error_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      idx_q            <= idx_d;
      tmo_q            <= tmo_d;
      rx_len_q         <= rx_len_d;
      mism_q           <= mism_d;
      stat_good_q      <= stat_good_d;
      stat_bad_q       <= stat_bad_d;
      conf_rx_en_q     <= 1'b1;
      frame_received_q <= frame_received_d;
      frame_error_q    <= frame_error_d;
    end
  end

  assign conf_rx_en         = conf_rx_en_q;
  assign conf_rx_jumbo_en   = 1'b0;
  assign conf_rx_no_chk_crc = 1'b0;
  assign frame_received     = frame_received_q;
  assign frame_error        = frame_error_q;
  assign rx_len             = rx_len_q;

`ifdef FRAME_RECEIVER_STATS_EN
  logic timeout_q;

  always_ff @(posedge rx_clk or posedge reset) begin
    if (reset) timeout_q <= 1'b0;
    else       timeout_q <= timeout_d;
  end

  frame_rx_stats u_stats (
    .clk           (rx_clk),
    .rst           (reset),
    .good_pulse    (frame_received_q),
    .err_pulse     (frame_error_q),
    .timeout_pulse (timeout_q),
    .good_cnt      (good_cnt),
    .err_cnt       (err_cnt),
    .timeout_cnt   (timeout_cnt)
  );
`else
  logic unused_timeout;
  assign unused_timeout = timeout_d;
`endif

endmodule

// File: tb/tb_frame_receiver.sv
// tb/tb_frame_receiver.sv - scoreboard bench for frame_receiver
module tb_frame_receiver;
  import frame_pkg::*;

  logic        rx_clk = 1'b0;
  logic        reset;
  logic        conf_rx_en, conf_rx_jumbo_en, conf_rx_no_chk_crc;
  logic [7:0]  mac_rx_data;
  logic        mac_rx_dvld, mac_rx_goodframe, mac_rx_badframe;
  logic        frame_received, frame_error;
  logic [15:0] rx_len;
`ifdef FRAME_RECEIVER_STATS_EN
  logic [15:0] good_cnt, err_cnt, timeout_cnt;
`endif

  frame_receiver dut (
    .rx_clk             (rx_clk),
    .reset              (reset),
    .conf_rx_en         (conf_rx_en),
    .conf_rx_jumbo_en   (conf_rx_jumbo_en),
    .conf_rx_no_chk_crc (conf_rx_no_chk_crc),
    .mac_rx_data        (mac_rx_data),
    .mac_rx_dvld        (mac_rx_dvld),
    .mac_rx_goodframe   (mac_rx_goodframe),
    .mac_rx_badframe    (mac_rx_badframe),
    .frame_received     (frame_received),
    .frame_error        (frame_error),
    .rx_len             (rx_len)
`ifdef FRAME_RECEIVER_STATS_EN
    ,
    .good_cnt           (good_cnt),
    .err_cnt            (err_cnt),
    .timeout_cnt        (timeout_cnt)
`endif
  );

  always #5 rx_clk = ~rx_clk;

  typedef struct {
    logic        good;
    logic [15:0] len;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  int           compared   = 0;
  int           mismatched = 0;
  logic [479:0] frame_bits = SAMPLE_FRAME;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] frame_byte(input int i);
    if (i < 60) return frame_bits[8*(60-i)-1 -: 8];
    return 8'(8'hA0 + i);
  endfunction

  task automatic tick();
    @(posedge rx_clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic drive_byte(input int i, input int bad_idx, input logic [7:0] bad_val);
    mac_rx_dvld = 1'b1;
    mac_rx_data = (i == bad_idx) ? bad_val : frame_byte(i);
  endtask

  task automatic send(input int n, input int bad_idx, input logic [7:0] bad_val, input logic good_last);
    for (int i = 0; i < n; i++) begin
      drive_byte(i, bad_idx, bad_val);
      mac_rx_goodframe = good_last && (i == n - 1);
      tick();
    end
    mac_rx_dvld      = 1'b0;
    mac_rx_data      = 8'h00;
    mac_rx_goodframe = 1'b0;
  endtask

  task automatic status(input logic g, input logic b);
    mac_rx_goodframe = g;
    mac_rx_badframe  = b;
    tick();
    mac_rx_goodframe = 1'b0;
    mac_rx_badframe  = 1'b0;
  endtask

  task automatic push(input logic g, input logic [15:0] len);
    exp_t e;
    e.good = g;
    e.len  = len;
    sb.push_back(e);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
    check(tag, sb.size(), 0);
  endtask

  always @(negedge rx_clk) begin
    if (!reset && (frame_received || frame_error)) begin
      check("pulse_exclusive", frame_received & frame_error, 0);
      if (sb.size() == 0) begin
        check("unexpected_pulse", {frame_received, frame_error}, 0);
      end else begin
        mon_e = sb.pop_front();
        check("result_kind", frame_received, mon_e.good);
        check("result_rx_len", rx_len, mon_e.len);
      end
    end
  end

  initial begin
    reset            = 1'b1;
    mac_rx_data      = 8'h00;
    mac_rx_dvld      = 1'b0;
    mac_rx_goodframe = 1'b0;
    mac_rx_badframe  = 1'b0;
    idle(3);
    check("rst_conf_rx_en", conf_rx_en, 0);
    check("rst_jumbo", conf_rx_jumbo_en, 0);
    check("rst_no_chk_crc", conf_rx_no_chk_crc, 0);
    check("rst_frame_received", frame_received, 0);
    check("rst_frame_error", frame_error, 0);
    check("rst_rx_len", rx_len, 0);
    reset = 1'b0;
    check("conf_rx_en_before_edge", conf_rx_en, 0);
    tick();
    check("conf_rx_en_after_edge", conf_rx_en, 1);
    idle(2);

    // Clean frame, goodframe two cycles after dvld falls, exact latency.
    push(1'b1, 16'd60);
    send(60, -1, 8'h00, 1'b0);
    idle(2);
    mac_rx_goodframe = 1'b1;
    check("good_not_early", frame_received, 0);
    tick();
    mac_rx_goodframe = 1'b0;
    check("good_latency", frame_received, 1);
    check("good_rx_len", rx_len, 60);
    tick();
    check("good_one_cycle", frame_received, 0);
    drain("drain_clean");

    // Ethertype byte corrupted.
    push(1'b0, 16'd60);
    send(60, 12, 8'h09, 1'b0);
    idle(2);
    status(1'b1, 1'b0);
    drain("drain_corrupt");

    // Frame plus FCS, goodframe on the last dvld cycle.
    push(1'b1, 16'd64);
    send(64, -1, 8'h00, 1'b1);
    drain("drain_fcs");

    // No status: timeout fires exactly after 16 STATUS cycles.
    push(1'b0, 16'd60);
    send(60, -1, 8'h00, 1'b0);
    idle(16);
    check("timeout_not_early", frame_error, 0);
    tick();
    check("timeout_fires", frame_error, 1);
    drain("drain_timeout");
    idle(2);
`ifdef FRAME_RECEIVER_STATS_EN
    check("stats_timeout_cnt", timeout_cnt, 1);
    check("stats_good_cnt", good_cnt, 2);
    check("stats_err_cnt", err_cnt, 2);
`endif

    // Reset for three cycles in the middle of a frame.
    for (int i = 0; i < 20; i++) begin
      drive_byte(i, -1, 8'h00);
      tick();
    end
    reset = 1'b1;
    for (int i = 20; i < 23; i++) begin
      drive_byte(i, -1, 8'h00);
      tick();
    end
    check("midrst_conf_rx_en", conf_rx_en, 0);
    reset = 1'b0;
    for (int i = 23; i < 60; i++) begin
      drive_byte(i, -1, 8'h00);
      tick();
    end
    mac_rx_dvld = 1'b0;
    idle(2);
    status(1'b1, 1'b0);
    idle(25);
    check("midrst_rx_len", rx_len, 0);
    push(1'b1, 16'd60);
    send(60, -1, 8'h00, 1'b0);
    idle(1);
    status(1'b1, 1'b0);
    drain("drain_after_reset");

    // goodframe and badframe together count as bad.
    push(1'b0, 16'd60);
    send(60, -1, 8'h00, 1'b0);
    idle(1);
    status(1'b1, 1'b1);
    drain("drain_both_status");

    // Short frame.
    push(1'b0, 16'd30);
    send(30, -1, 8'h00, 1'b0);
    idle(1);
    status(1'b1, 1'b0);
    drain("drain_short");

    // One-cycle gap carrying the first frame's status.
    push(1'b1, 16'd60);
    push(1'b1, 16'd60);
    send(60, -1, 8'h00, 1'b0);
    status(1'b1, 1'b0);
    send(60, -1, 8'h00, 1'b0);
    idle(2);
    status(1'b1, 1'b0);
    drain("drain_back_to_back");

    // New frame starts while the previous one waits for status.
    push(1'b0, 16'd60);
    push(1'b1, 16'd60);
    send(60, -1, 8'h00, 1'b0);
    idle(1);
    send(60, -1, 8'h00, 1'b0);
    idle(2);
    status(1'b1, 1'b0);
    drain("drain_preempt");

    idle(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
